// File: rtl/vend_credit_ctrl.sv
// vend_credit_ctrl
//   Credit/vend controller. Debounced active-low buttons are synchronised and
//   edge-detected, coin presses accumulate credit up to MAX_CREDIT, a buy
//   against the switch price runs a fixed-length dispense and then pays out
//   change, and a refund returns the whole credit.
//
// Ports
//   CLOCK_50      in   system clock, rising edge
//   RESET_N       in   async active-low reset
//   coin_n        in   NUM_COINS active-low coin buttons (async)
//   buy_n         in   active-low buy button (async)
//   refund_n      in   active-low refund button (async)
//   price         in   item price, sampled when a buy is taken
//   credit        out  accumulated credit
//   dispense      out  high DISPENSE_CYCLES cycles per vend
//   change        out  change/refund amount, updated with change_valid
//   change_valid  out  one-cycle pulse
//   coin_reject   out  one-cycle pulse, coin event(s) discarded
//   insufficient  out  one-cycle pulse, buy refused
//   busy          out  high whenever not IDLE
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | accepting coins, buy and refund
// DISPENSE  | dispense high, counter runs down to zero
// CHANGE    | one cycle, latched change presented with change_valid
module vend_credit_ctrl #(
  parameter int                            CREDIT_W        = 8,
  parameter int                            NUM_COINS       = 3,
  parameter logic [NUM_COINS*CREDIT_W-1:0] COIN_VALUES     = {8'd10, 8'd5, 8'd1},
  parameter int                            MAX_CREDIT      = 255,
  parameter int                            DISPENSE_CYCLES = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_N,
  input  logic [NUM_COINS-1:0] coin_n,
  input  logic                 buy_n,
  input  logic                 refund_n,
  input  logic [CREDIT_W-1:0]  price,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 dispense,
  output logic [CREDIT_W-1:0]  change,
  output logic                 change_valid,
  output logic                 coin_reject,
  output logic                 insufficient,
  output logic                 busy
);

  localparam int NB    = NUM_COINS + 2;
  localparam int SUM_W = CREDIT_W + 4;
  localparam int CNT_W = $clog2(DISPENSE_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DISPENSE, ST_CHANGE} state_t;

  logic [NB-1:0]       btn_raw;
  logic [NB-1:0]       sync1_q, sync2_q, hist_q;
  logic [NB-1:0]       ev;
  logic [NUM_COINS-1:0] coin_ev;
  logic                buy_ev, refund_ev;
  logic [SUM_W-1:0]    coin_sum;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic [CREDIT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cv_q, cv_d;
  logic                rej_q, rej_d;
  logic                ins_q, ins_d;
  logic                disp_q, disp_d;

  assign btn_raw   = {refund_n, buy_n, coin_n};
  // press edge: synchronised level low while the previous sample was high
  assign ev        = hist_q & ~sync2_q;
  assign coin_ev   = ev[NUM_COINS-1:0];
  assign buy_ev    = ev[NUM_COINS];
  assign refund_ev = ev[NUM_COINS+1];

  // widened so a full batch of coins on top of any credit cannot wrap
  always_comb begin
    coin_sum = SUM_W'(credit_q);
    for (int i = 0; i < NUM_COINS; i++) begin
      if (coin_ev[i]) coin_sum = coin_sum + SUM_W'(COIN_VALUES[i*CREDIT_W +: CREDIT_W]);
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    change_d = change_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    cv_d     = 1'b0;
    rej_d    = 1'b0;
    ins_d    = 1'b0;
    disp_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (refund_ev) begin
          change_d = credit_q;
          credit_d = '0;
          cv_d     = 1'b1;
          rej_d    = |coin_ev;
        end else if (buy_ev) begin
          // any buy press owns the cycle; coins arriving with it are dropped
          rej_d = |coin_ev;
          if ((price != '0) && (credit_q >= price)) begin
            pend_d   = credit_q - price;
            credit_d = '0;
            cnt_d    = CNT_W'(DISPENSE_CYCLES - 1);
            disp_d   = 1'b1;
            state_d  = ST_DISPENSE;
          end else begin
            ins_d = 1'b1;
          end
        end else if (|coin_ev) begin
          if (coin_sum <= SUM_W'(MAX_CREDIT)) credit_d = coin_sum[CREDIT_W-1:0];
          else                                rej_d    = 1'b1;
        end
      end
      ST_DISPENSE: begin
        rej_d = |coin_ev;
        if (cnt_q == '0) begin
          change_d = pend_q;
          cv_d     = 1'b1;
          state_d  = ST_CHANGE;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          disp_d = 1'b1;
        end
      end
      ST_CHANGE: begin
        rej_d   = |coin_ev;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      hist_q   <= '1;
      state_q  <= ST_IDLE;
      credit_q <= '0;
      change_q <= '0;
      pend_q   <= '0;
      cnt_q    <= '0;
      cv_q     <= 1'b0;
      rej_q    <= 1'b0;
      ins_q    <= 1'b0;
      disp_q   <= 1'b0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      hist_q   <= sync2_q;
      state_q  <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      cv_q     <= cv_d;
      rej_q    <= rej_d;
      ins_q    <= ins_d;
      disp_q   <= disp_d;
    end
  end

  assign credit       = credit_q;
  assign change       = change_q;
  assign change_valid = cv_q;
  assign coin_reject  = rej_q;
  assign insufficient = ins_q;
  assign dispense     = disp_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Bench for vend_credit_ctrl: directed scenarios followed by random button
// traffic, with every output compared each cycle against a transaction-level
// model (credit arithmetic plus a count of remaining busy cycles).
module tb_vend_credit_ctrl;

  localparam int CW   = 8;
  localparam int NC   = 3;
  localparam int NB   = NC + 2;
  localparam int MAXC = 20;
  localparam int DC   = 4;

  localparam logic [NB-1:0] C0  = 5'b00001;
  localparam logic [NB-1:0] C1  = 5'b00010;
  localparam logic [NB-1:0] C2  = 5'b00100;
  localparam logic [NB-1:0] BUY = 5'b01000;
  localparam logic [NB-1:0] REF = 5'b10000;

  logic          CLOCK_50 = 1'b0;
  logic          RESET_N  = 1'b1;
  logic [NB-1:0] btn_n    = '1;
  logic [CW-1:0] price    = '0;
  logic [CW-1:0] credit, change;
  logic          dispense, change_valid, coin_reject, insufficient, busy;

  int n_tests = 0;
  int n_fail  = 0;

  vend_credit_ctrl #(
    .CREDIT_W       (CW),
    .NUM_COINS      (NC),
    .COIN_VALUES    ({8'd10, 8'd5, 8'd1}),
    .MAX_CREDIT     (MAXC),
    .DISPENSE_CYCLES(DC)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .coin_n      (btn_n[NC-1:0]),
    .buy_n       (btn_n[NC]),
    .refund_n    (btn_n[NC+1]),
    .price       (price),
    .credit      (credit),
    .dispense    (dispense),
    .change      (change),
    .change_valid(change_valid),
    .coin_reject (coin_reject),
    .insufficient(insufficient),
    .busy        (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int            coin_val[NC] = '{1, 5, 10};
  int            m_credit = 0, m_change = 0, m_pend = 0, m_left = 0;
  bit            m_cv = 0, m_rej = 0, m_ins = 0;
  logic [NB-1:0] h0 = '1, h1 = '1, h2 = '1;

  // m_left = busy cycles still to come; last one is the change cycle
  always @(posedge CLOCK_50 or negedge RESET_N) begin : model
    int            c, chg, pend, left, sum;
    bit            cv, rej, ins;
    logic [NB-1:0] ev;
    logic [NC-1:0] coins;
    if (!RESET_N) begin
      m_credit <= 0; m_change <= 0; m_pend <= 0; m_left <= 0;
      m_cv <= 0; m_rej <= 0; m_ins <= 0;
      h0 <= '1; h1 <= '1; h2 <= '1;
    end else begin
      c = m_credit; chg = m_change; pend = m_pend; left = m_left;
      cv = 0; rej = 0; ins = 0;
      // a press is seen two edges after it is first sampled
      ev    = h2 & ~h1;
      coins = ev[NC-1:0];
      if (left > 0) begin
        rej  = (coins != 0);
        left = left - 1;
        if (left == 1) begin cv = 1; chg = pend; end
      end else if (ev[NC+1]) begin
        chg = c; c = 0; cv = 1; rej = (coins != 0);
      end else if (ev[NC]) begin
        rej = (coins != 0);
        if (price != 0 && c >= int'(price)) begin
          pend = c - int'(price); c = 0; left = DC + 1;
        end else ins = 1;
      end else if (coins != 0) begin
        sum = c;
        for (int i = 0; i < NC; i++) if (coins[i]) sum = sum + coin_val[i];
        if (sum <= MAXC) c = sum; else rej = 1;
      end
      m_credit <= c; m_change <= chg; m_pend <= pend; m_left <= left;
      m_cv <= cv; m_rej <= rej; m_ins <= ins;
      h2 <= h1; h1 <= h0; h0 <= btn_n;
    end
  end

  int tot_disp = 0, tot_busy = 0, tot_cv = 0, tot_rej = 0, tot_ins = 0;

  always @(negedge CLOCK_50) begin
    chk("credit",       credit,       m_credit);
    chk("change",       change,       m_change);
    chk("dispense",     dispense,     int'(m_left > 1));
    chk("busy",         busy,         int'(m_left > 0));
    chk("change_valid", change_valid, int'(m_cv));
    chk("coin_reject",  coin_reject,  int'(m_rej));
    chk("insufficient", insufficient, int'(m_ins));
    tot_disp <= tot_disp + int'(dispense);
    tot_busy <= tot_busy + int'(busy);
    tot_cv   <= tot_cv   + int'(change_valid);
    tot_rej  <= tot_rej  + int'(coin_reject);
    tot_ins  <= tot_ins  + int'(insufficient);
  end

  task automatic press(input logic [NB-1:0] m, input int hold);
    @(negedge CLOCK_50);
    btn_n = ~m;
    repeat (hold) @(negedge CLOCK_50);
    btn_n = '1;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  int d0, b0, v0, r0, i0;
  int acc[3] = '{1, 6, 16};
  logic [NB-1:0] cm[3] = '{C0, C1, C2};

  initial begin
    #1 RESET_N = 1'b0;
    gap(3);
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dispense", dispense, 0);
    chk("rst_change", change, 0);
    RESET_N = 1'b1;
    gap(2);

    // coins 1,5,10, update exactly two edges after sampling
    begin
      int prev;
      prev = 0;
      r0 = tot_rej; i0 = tot_ins; v0 = tot_cv;
      for (int i = 0; i < 3; i++) begin
        press(cm[i], 1);
        gap(1);
        chk("coin_latency", credit, prev);
        gap(1);
        chk("coin_update", credit, acc[i]);
        prev = acc[i];
      end
      gap(1);
      chk("coin_no_pulses", (tot_rej - r0) + (tot_ins - i0) + (tot_cv - v0), 0);
    end

    // vend with change 3
    price = 8'd13;
    d0 = tot_disp; b0 = tot_busy; v0 = tot_cv;
    press(BUY, 1);
    gap(12);
    chk("vend_dispense_cycles", tot_disp - d0, 4);
    chk("vend_busy_cycles", tot_busy - b0, 5);
    chk("vend_change_pulses", tot_cv - v0, 1);
    chk("vend_change", change, 3);
    chk("vend_credit", credit, 0);

    // insufficient, then refund
    press(C0, 1); press(C1, 1); gap(3);
    chk("credit_6", credit, 6);
    i0 = tot_ins; d0 = tot_disp;
    press(BUY, 1); gap(4);
    chk("insufficient_pulse", tot_ins - i0, 1);
    chk("insufficient_no_vend", tot_disp - d0, 0);
    chk("insufficient_credit", credit, 6);
    v0 = tot_cv;
    press(REF, 1); gap(4);
    chk("refund_pulse", tot_cv - v0, 1);
    chk("refund_change", change, 6);
    chk("refund_credit", credit, 0);

    // overflow of MAX_CREDIT rejects the whole batch
    press(C2, 1); press(C1, 1); press(C0, 1); gap(3);
    chk("credit_16", credit, 16);
    r0 = tot_rej;
    press(C1 | C2, 1); gap(3);
    chk("overflow_reject", tot_rej - r0, 1);
    chk("overflow_credit", credit, 16);
    press(C0, 1); gap(3);
    chk("credit_17", credit, 17);

    // coin + buy while dispensing
    d0 = tot_disp; r0 = tot_rej; v0 = tot_cv;
    press(BUY, 1);
    gap(2);
    press(C2 | BUY, 1);
    gap(14);
    chk("busy_dispense_cycles", tot_disp - d0, 4);
    chk("busy_coin_reject", tot_rej - r0, 1);
    chk("busy_change_pulses", tot_cv - v0, 1);
    chk("busy_change", change, 4);
    chk("busy_credit", credit, 0);

    // held coin counts once
    press(C0, 50); gap(4);
    chk("held_coin_credit", credit, 1);

    // reset in the second dispense cycle
    press(C2, 1); gap(3);
    chk("credit_11", credit, 11);
    price = 8'd5;
    press(BUY, 1);
    gap(2);
    chk("pre_abort_dispense", dispense, 1);
    @(posedge CLOCK_50);
    #1 RESET_N = 1'b0;
    #1;
    chk("abort_dispense", dispense, 0);
    chk("abort_busy", busy, 0);
    chk("abort_credit", credit, 0);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    v0 = tot_cv;
    gap(12);
    chk("abort_no_change", tot_cv - v0, 0);
    chk("abort_credit_after", credit, 0);

    // random traffic, model checks every cycle
    for (int n = 0; n < 300; n++) begin
      int r;
      logic [NB-1:0] m;
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) price = CW'($urandom_range(0, 20));
      if (r < 5)       m = NB'($urandom_range(1, 7));
      else if (r < 7)  m = BUY;
      else if (r == 7) m = REF;
      else if (r == 8) m = NB'($urandom_range(1, 31));
      else             m = '0;
      press(m, $urandom_range(1, 3));
      gap($urandom_range(0, 5));
    end
    gap(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_credit_ctrl.md
Name: vend_credit_ctrl

Overview:
- Parametrised credit/vend controller for the DE0-CV board flow, successor to the fixed three-button coin design.
- Accepts NUM_COINS active-low pushbutton coin inputs with configurable denominations and accumulates credit against a switch-set price.
- Runs a dispense sequence of configurable length, then returns change; also supports a refund request.
- Sits between board I/O (KEY/SW debounced upstream) and LED/display drivers.

Parameters:
- CREDIT_W, 8, width of credit, price and change.
- NUM_COINS, 3, number of coin inputs (1..8).
- COIN_VALUES, {8'd10,8'd5,8'd1}, packed NUM_COINS*CREDIT_W denominations; slice i = value of coin_n[i].
- MAX_CREDIT, 255, highest credit accepted (<= 2^CREDIT_W-1).
- DISPENSE_CYCLES, 4, cycles dispense stays high (>=1).

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- coin_n  in  NUM_COINS  active-low coin buttons, asynchronous to clock.
- buy_n  in  1  active-low purchase button, asynchronous.
- refund_n  in  1  active-low refund button, asynchronous.
- price  in  CREDIT_W  item price, static switches, sampled when buy is accepted.
- credit  out  CREDIT_W  current accumulated credit.
- dispense  out  1  high for DISPENSE_CYCLES during vend.
- change  out  CREDIT_W  change/refund amount, valid with change_valid.
- change_valid  out  1  one-cycle pulse.
- coin_reject  out  1  one-cycle pulse: coin event discarded.
- insufficient  out  1  one-cycle pulse: buy with credit < price or price == 0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE, credit 0, change 0, all pulses/dispense/busy 0, synchronisers and edge history loaded to 1 (released).
- Inputs: every button bit passes a 2-flop synchroniser plus a history flop. Event = synced 0 and history 1 (press edge). One event per press; holding produces nothing further.
- Latency: press sampled on edge k yields the state/credit update on edge k+2. Outputs reflect it from then on.
- FSM states: IDLE, DISPENSE, CHANGE.
- IDLE priority per cycle: refund > buy > coins.
  - Refund event: change <= credit, credit <= 0, change_valid pulse. Refund with credit 0 still pulses, with change 0. Remains IDLE.
  - Buy event, price != 0 and credit >= price: latch change <= credit - price, credit <= 0, go DISPENSE, dispense = 1.
  - Buy event, otherwise: insufficient pulse; credit unchanged.
  - Coin events, no refund/buy: sum = credit + all simultaneously pressed denominations, computed at CREDIT_W+4 bits. If sum <= MAX_CREDIT, credit <= sum; else credit unchanged and coin_reject pulse (whole batch rejected).
  - Coin events coincident with an accepted buy or refund: discarded, coin_reject pulse.
- DISPENSE: dispense high exactly DISPENSE_CYCLES cycles via internal counter, then CHANGE.
- CHANGE: one cycle. change_valid pulse with the latched change (0 if exact price), then IDLE.
- busy = (state != IDLE). All button events while busy are discarded. Coin events during busy also pulse coin_reject; buy/refund events are silently dropped.
- change holds its last value until the next change_valid.
- RESET_N assertion mid-DISPENSE aborts immediately. Credit is lost, no change issued.

Test Plan:
- Reset, press coin 0,1,2 once each (values 1,5,10) -> credit 1, 6, 16, each update 2 edges after sampling; no pulses.
- credit 16, price 13, buy -> dispense high 4 cycles, credit 0, busy high 5 cycles, then change_valid with change 3.
- credit 6, price 13, buy -> insufficient pulse, credit stays 6; refund -> change_valid, change 6, credit 0.
- MAX_CREDIT 20, credit 16, press coin 1 and coin 2 same cycle -> coin_reject, credit 16; press coin 0 -> credit 17.
- During DISPENSE press coin 2 and buy -> coin_reject pulse, credit 0 after CHANGE, no second vend; hold coin 0 low 50 cycles -> exactly +1.
- Assert RESET_N low in 2nd dispense cycle -> dispense, busy, credit 0 immediately; no change_valid after release.
